serial_byte_sender: RTL and testbench



---
 rtl/serial_byte_sender.sv | 191 +++++++++++++++++++
 tb/tb_serial_byte_sender.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_sender.sv
// serial_byte_sender
//   Takes parallel bytes over a valid/ready handshake and replays each one MSB
//   first as a data bit plus a timed write strobe. Before every bit it waits
//   for the downstream queue to report not-busy (status_in == 0).
//   The bit window is PULSE_CYCLES of write high followed by GAP_CYCLES of
//   write low. Together with the single WAIT cycle that samples status_in,
//   one bit takes 1 + PULSE_CYCLES + GAP_CYCLES clocks.
//   Optional feature: define SENDER_TIMEOUT_EN to abort a byte that waits
//   too long on a busy downstream. The abort raises a sticky err_timeout.
//   Without the macro, WAIT waits forever and err_timeout is tied low.
module serial_byte_sender #(
  parameter int PULSE_CYCLES   = 10,
  parameter int GAP_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clock1M,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       status_in,
  output logic       data_out,
  output logic       write_out,
  output logic       busy_out,
  output logic [7:0] bytes_sent,
  output logic       err_timeout
);

  // One shared cycle counter serves PULSE, GAP and (optionally) WAIT timing.
  // It is sized to hold the largest of the three terminal counts.
  localparam int MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_PG > TIMEOUT_CYCLES) ? MAX_PG : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
`ifdef SENDER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           state_q,   state_d;
  logic [7:0]       shift_q,   shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic             ready_q,   ready_d;
  logic             data_q,    data_d;
  logic             write_q,   write_d;
  logic             busy_q,    busy_d;
  logic [7:0]       sent_q,    sent_d;
`ifdef SENDER_TIMEOUT_EN
  logic             err_q,     err_d;
`endif

  logic transfer;

  // byte_ready is registered and is high exactly in IDLE.
  // A handshake therefore only ever completes from the IDLE state.
  assign transfer = byte_valid & ready_q;

  // Next-state and next-output computation for the bit-replay sequencer.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    data_d    = data_q;
    write_d   = write_q;
    sent_d    = sent_q;
`ifdef SENDER_TIMEOUT_EN
    err_d     = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          shift_d   = byte_in;
          bit_cnt_d = 3'd0;
          cyc_cnt_d = '0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // The data bit only moves here, so it never changes under a high strobe.
        if (!status_in) begin
          data_d    = shift_q[7];
          write_d   = 1'b1;
          cyc_cnt_d = '0;
          state_d   = ST_PULSE;
        end
`ifdef SENDER_TIMEOUT_EN
        // Count busy cycles. On the last one, drop the partial byte.
        else if (cyc_cnt_q == TIMEOUT_LAST) begin
          err_d     = 1'b1;
          cyc_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_PULSE: begin
        // status_in is deliberately ignored while the strobe is high.
        if (cyc_cnt_q == PULSE_LAST) begin
          write_d   = 1'b0;
          cyc_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cyc_cnt_q == GAP_LAST) begin
          shift_d   = {shift_q[6:0], 1'b0};
          cyc_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            sent_d  = sent_q + 8'd1;
            state_d = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = ST_WAIT;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are derived from the next state so they are valid the
    // same cycle the state register changes. This lets a new byte be accepted
    // in the very first IDLE cycle.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers. Reset discards any partially sent byte.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      cyc_cnt_q <= '0;
      ready_q   <= 1'b1;
      data_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= 8'd0;
`ifdef SENDER_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
`ifdef SENDER_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign byte_ready = ready_q;
  assign data_out   = data_q;
  assign write_out  = write_q;
  assign busy_out   = busy_q;
  assign bytes_sent = sent_q;
`ifdef SENDER_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_sender.sv
// tb_serial_byte_sender
//   Directed bench for serial_byte_sender. A behavioural model describes each
//   byte as eight bit windows: wait for a free downstream, then a fixed
//   PULSE+GAP window. Every cycle, the DUT outputs are compared with that model.
//   Hand-computed literals pin latencies, pulse widths and received bytes.
//   The timeout scenario follows SENDER_TIMEOUT_EN.
module tb_serial_byte_sender;

  localparam int PULSE = 10;
  localparam int GAP   = 10;
  localparam int TOUT  = 64;
`ifdef SENDER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       status_in;
  logic       data_out;
  logic       write_out;
  logic       busy_out;
  logic [7:0] bytes_sent;
  logic       err_timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mon_rises = 0;
  bit chk_en = 1'b0;
  bit chk_period = 1'b0;
  logic [7:0] rx_q[$];

  serial_byte_sender #(
    .PULSE_CYCLES  (PULSE),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clock1M    (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .status_in  (status_in),
    .data_out   (data_out),
    .write_out  (write_out),
    .busy_out   (busy_out),
    .bytes_sent (bytes_sent),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model.
  // m_left == 0 while busy means the sender is waiting on status_in.
  // Otherwise m_left counts down the remaining cycles of the current bit window.
  bit         m_busy;
  int         m_left;
  int         m_bit;
  int         m_wait;
  logic [7:0] m_byte;
  logic       m_data;
  logic [7:0] m_sent;
  logic       m_err;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_busy = 1'b0; m_left = 0; m_bit = 0; m_wait = 0;
      m_byte = 8'd0; m_data = 1'b0; m_sent = 8'd0; m_err = 1'b0;
    end else if (!m_busy) begin
      if (byte_valid) begin
        m_busy = 1'b1; m_byte = byte_in; m_bit = 0; m_left = 0; m_wait = 0;
      end
    end else if (m_left == 0) begin
      if (!status_in) begin
        m_left = PULSE + GAP;
        m_data = m_byte[7 - m_bit];
      end else if (TO_EN) begin
        m_wait = m_wait + 1;
        if (m_wait == TOUT) begin
          m_busy = 1'b0;
          m_err  = 1'b1;
        end
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_bit == 7) begin
          m_busy = 1'b0;
          m_sent = m_sent + 8'd1;
        end else begin
          m_bit  = m_bit + 1;
          m_wait = 0;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model, on the falling edge.
  initial forever begin
    logic [12:0] exp_v;
    logic [12:0] act_v;
    @(negedge clk);
    if (chk_en) begin
      exp_v = {~m_busy, m_busy, (m_busy && (m_left > GAP)), m_data, m_sent, m_err};
      act_v = {byte_ready, busy_out, write_out, data_out, bytes_sent, err_timeout};
      check("model_cmp {rdy,busy,wr,data,sent,err}", 32'(act_v), 32'(exp_v));
    end
  end

  // Strobe monitor.
  // It rebuilds bytes from data_out at each rising write_out and checks the
  // pulse width. When chk_period is set, it also checks the bit-to-bit period
  // inside a byte.
  initial forever begin
    logic       prev_w;
    int         hi_cnt;
    int         nbits;
    int         last_rise;
    logic [7:0] shreg;
    @(negedge clk);
    if (!reset) begin
      prev_w = 1'b0; hi_cnt = 0; nbits = 0; last_rise = -1; shreg = 8'd0;
    end else begin
      if (write_out && !prev_w) begin
        mon_rises++;
        shreg = {shreg[6:0], data_out};
        nbits++;
        if (chk_period && nbits > 1 && last_rise >= 0)
          check("bit_period", cyc - last_rise, 21);
        last_rise = cyc;
        if (nbits == 8) begin
          rx_q.push_back(shreg);
          nbits = 0;
        end
      end
      if (write_out) begin
        hi_cnt++;
      end else if (prev_w) begin
        check("pulse_width", hi_cnt, 10);
        hi_cnt = 0;
      end
      prev_w = write_out;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] b, output int t_acc);
    int n;
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("offer_ready", 32'(byte_ready), 1);
    tick();
    t_acc = cyc;
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    while (byte_ready !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(byte_ready), 1);
  endtask

  task automatic wait_rises(input int target, input int lim);
    int n;
    n = 0;
    while (mon_rises < target && n < lim) begin
      tick();
      n++;
    end
    check("wait_rises", mon_rises, target);
  endtask

  task automatic expect_rx(input string name, input logic [7:0] exp);
    logic [7:0] got;
    check({name, "_avail"}, 32'(rx_q.size() > 0), 1);
    if (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      check(name, 32'(got), 32'(exp));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    rx_q.delete();
    tick();
  endtask

  initial begin
    int ta;
    int prev_ta;
    int r0;
    reset      = 1'b1;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    status_in  = 1'b0;

    // 1: reset held low for 10 cycles.
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (10) tick();
    check("t1_ready", 32'(byte_ready), 1);
    check("t1_write", 32'(write_out), 0);
    check("t1_data",  32'(data_out), 0);
    check("t1_busy",  32'(busy_out), 0);
    check("t1_sent",  32'(bytes_sent), 0);
    check("t1_err",   32'(err_timeout), 0);
    reset = 1'b1;
    tick();

    // 2: 0xA5 with a free downstream. Expected bits are 1,0,1,0,0,1,0,1.
    // The bit period is 21 and the byte takes 168 cycles.
    chk_period = 1'b1;
    r0 = mon_rises;
    offer(8'hA5, ta);
    byte_valid = 1'b0;
    wait_ready(400);
    check("t2_latency", cyc - ta, 168);
    check("t2_pulses", mon_rises - r0, 8);
    expect_rx("t2_byte", 8'hA5);
    check("t2_sent", 32'(bytes_sent), 1);
    chk_period = 1'b0;

    // 3: backpressure after bit 3 for 500 cycles, byte 0x96.
    r0 = mon_rises;
    offer(8'h96, ta);
    byte_valid = 1'b0;
    wait_rises(r0 + 4, 200);
    status_in = 1'b1;
    r0 = mon_rises;
    repeat (500) tick();
    check("t3_no_pulse_in_hold", mon_rises, r0);
    check("t3_hold_write", 32'(write_out), 0);
    check("t3_hold_busy", 32'(busy_out), 1);
    status_in = 1'b0;
    tick();
    check("t3_resume_write", 32'(write_out), 1);
    check("t3_resume_rise", mon_rises, r0 + 1);
    wait_ready(400);
    expect_rx("t3_byte", 8'h96);
    check("t3_sent", 32'(bytes_sent), 2);

    // 4: asynchronous reset during the bit 2 pulse, then a clean 0x3C.
    r0 = mon_rises;
    offer(8'hFF, ta);
    byte_valid = 1'b0;
    wait_rises(r0 + 3, 200);
    repeat (3) tick();
    check("t4_pre_write", 32'(write_out), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t4_async_write", 32'(write_out), 0);
    check("t4_async_data",  32'(data_out), 0);
    check("t4_async_ready", 32'(byte_ready), 1);
    check("t4_async_busy",  32'(busy_out), 0);
    check("t4_async_sent",  32'(bytes_sent), 0);
    repeat (3) tick();
    reset = 1'b1;
    rx_q.delete();
    tick();
    offer(8'h3C, ta);
    byte_valid = 1'b0;
    wait_ready(400);
    check("t4_latency", cyc - ta, 168);
    expect_rx("t4_byte", 8'h3C);
    check("t4_sent", 32'(bytes_sent), 1);

    // 5: 256 back-to-back bytes with byte_valid held high.
    // Accepts must be 168 + 1 cycles apart, and bytes_sent wraps to 0.
    do_reset();
    chk_period = 1'b1;
    prev_ta = 0;
    for (int i = 0; i < 256; i++) begin
      offer(8'(i), ta);
      if (i > 0) check("t5_accept_spacing", ta - prev_ta, 169);
      prev_ta = ta;
    end
    byte_valid = 1'b0;
    wait_ready(400);
    check("t5_rx_count", rx_q.size(), 256);
    for (int i = 0; i < 256; i++) expect_rx("t5_byte", 8'(i));
    check("t5_sent_wrap", 32'(bytes_sent), 0);
    chk_period = 1'b0;

    // 6: downstream stuck busy.
    do_reset();
    status_in = 1'b1;
    r0 = mon_rises;
    offer(8'h81, ta);
    byte_valid = 1'b0;
`ifdef SENDER_TIMEOUT_EN
    wait_ready(200);
    check("t6_abort_latency", cyc - ta, 64);
    check("t6_err", 32'(err_timeout), 1);
    check("t6_sent", 32'(bytes_sent), 0);
    check("t6_no_pulse", mon_rises, r0);
    status_in = 1'b0;
    offer(8'h42, ta);
    byte_valid = 1'b0;
    wait_ready(400);
    expect_rx("t6_next_byte", 8'h42);
    check("t6_err_sticky", 32'(err_timeout), 1);
    check("t6_sent_after", 32'(bytes_sent), 1);
`else
    repeat (200) tick();
    check("t6_still_busy", 32'(busy_out), 1);
    check("t6_err_zero", 32'(err_timeout), 0);
    check("t6_no_pulse", mon_rises, r0);
    status_in = 1'b0;
    wait_ready(400);
    expect_rx("t6_byte", 8'h81);
    check("t6_sent", 32'(bytes_sent), 1);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
